// File: rtl/fifo_ctrl.sv
// 8 x 32-bit synchronous FIFO with registered ack/err pulses and occupancy count.
// Optional almost_full/almost_empty outputs are enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        full,
  output logic        empty,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        rd_ack,
  output logic        rd_err,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic        almost_full,
  output logic        almost_empty,
`endif
  output logic [3:0]  data_count
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [3:0]        count;
  logic              do_wr;
  logic              do_rd;

  // Legality uses the pre-edge count, so a read at count 0 never sees a same-edge write.
  assign do_wr = wr_en && (count != 4'd8);
  assign do_rd = rd_en && (count != 4'd0);

  always_ff @(posedge clk) begin
    if (do_wr) mem[tail] <= d_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      d_out  <= '0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      wr_ack <= do_wr;
      wr_err <= wr_en && !do_wr;
      rd_ack <= do_rd;
      rd_err <= rd_en && !do_rd;
      if (do_wr) tail <= tail + 1'b1;
      if (do_rd) begin
        d_out <= mem[head];
        head  <= head + 1'b1;
      end
      count <= count + {3'b000, do_wr} - {3'b000, do_rd};
    end
  end

  assign data_count = count;
  assign full       = (count == 4'd8);
  assign empty      = (count == 4'd0);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count >= 4'd7);
  assign almost_empty = (count <= 4'd1);
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: queue-based reference model compared every cycle,
// plus directed fill/drain/wrap/simultaneous/reset scenarios and randomized traffic.
module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0]  data_count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic        almost_full, almost_empty;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  fifo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in),
    .d_out(d_out), .full(full), .empty(empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue plus last-edge results.
  logic [31:0] m_q [$];
  logic [31:0] m_dout = '0;
  bit m_wa = 0, m_we = 0, m_ra = 0, m_re = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_dout = '0;
      m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
    end else begin
      automatic bit ok_w = wr_en && (m_q.size() < 8);
      automatic bit ok_r = rd_en && (m_q.size() > 0);
      m_wa = ok_w;
      m_we = wr_en && !ok_w;
      m_ra = ok_r;
      m_re = rd_en && !ok_r;
      if (ok_r) m_dout = m_q.pop_front();
      if (ok_w) m_q.push_back(d_in);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model d_out", d_out, m_dout);
      check("model wr_ack", {31'b0, wr_ack}, {31'b0, m_wa});
      check("model wr_err", {31'b0, wr_err}, {31'b0, m_we});
      check("model rd_ack", {31'b0, rd_ack}, {31'b0, m_ra});
      check("model rd_err", {31'b0, rd_err}, {31'b0, m_re});
      check("model count", {28'b0, data_count}, m_q.size());
      check("model full", {31'b0, full}, {31'b0, (m_q.size() == 8)});
      check("model empty", {31'b0, empty}, {31'b0, (m_q.size() == 0)});
`ifdef FIFO_ALMOST_FLAGS_EN
      check("model almost_full", {31'b0, almost_full}, {31'b0, (m_q.size() >= 7)});
      check("model almost_empty", {31'b0, almost_empty}, {31'b0, (m_q.size() <= 1)});
`endif
    end
  end

  // Inputs change 1ns after a rising edge; returns 1ns after the next rising edge.
  task automatic step(bit w, bit r, logic [31:0] d);
    wr_en = w; rd_en = r; d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0);
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    reset_n = 1'b1;
    idle();
    check("reset d_out", d_out, 32'h0);
    check("reset empty", {31'b0, empty}, 32'd1);

    // Fill
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 32'h1000_0000 + i);
      check("fill wr_ack", {31'b0, wr_ack}, 32'd1);
      check("fill count", {28'b0, data_count}, i + 1);
    end
    check("fill full", {31'b0, full}, 32'd1);
    step(1, 0, 32'hDEAD_BEEF);
    check("overfill wr_err", {31'b0, wr_err}, 32'd1);
    check("overfill count", {28'b0, data_count}, 32'd8);

    // Drain
    for (int i = 0; i < 8; i++) begin
      step(0, 1, '0);
      check("drain d_out", d_out, 32'h1000_0000 + i);
      check("drain rd_ack", {31'b0, rd_ack}, 32'd1);
    end
    check("drain empty", {31'b0, empty}, 32'd1);
    step(0, 1, '0);
    check("underflow rd_err", {31'b0, rd_err}, 32'd1);
    check("underflow d_out hold", d_out, 32'h1000_0007);

    // Wrap: 5 in/out moves pointers to 5, then 8 more crosses 7->0
    for (int i = 0; i < 5; i++) step(1, 0, 32'h2000_0000 + i);
    for (int i = 0; i < 5; i++) step(0, 1, '0);
    check("wrap first d_out", d_out, 32'h2000_0004);
    for (int i = 0; i < 8; i++) step(1, 0, 32'h3000_0000 + i);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, '0);
      check("wrap d_out", d_out, 32'h3000_0000 + i);
    end

    // Simultaneous at count 0, 8, 3
    step(1, 1, 32'h4000_0000);
    check("sim0 wr_ack", {31'b0, wr_ack}, 32'd1);
    check("sim0 rd_err", {31'b0, rd_err}, 32'd1);
    check("sim0 count", {28'b0, data_count}, 32'd1);
    check("sim0 d_out hold", d_out, 32'h3000_0007);
    for (int i = 1; i < 8; i++) step(1, 0, 32'h4000_0000 + i);
    step(1, 1, 32'h4000_0008);
    check("sim8 rd_ack", {31'b0, rd_ack}, 32'd1);
    check("sim8 wr_err", {31'b0, wr_err}, 32'd1);
    check("sim8 count", {28'b0, data_count}, 32'd7);
    check("sim8 d_out", d_out, 32'h4000_0000);
    for (int i = 0; i < 4; i++) step(0, 1, '0);
    step(1, 1, 32'h4000_0009);
    check("sim3 wr_ack", {31'b0, wr_ack}, 32'd1);
    check("sim3 rd_ack", {31'b0, rd_ack}, 32'd1);
    check("sim3 count", {28'b0, data_count}, 32'd3);
    check("sim3 d_out", d_out, 32'h4000_0005);

    // Mid-run reset between edges
    idle();
    for (int i = 0; i < 4; i++) step(1, 0, 32'h5000_0000 + i);
    step(0, 1, '0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst count", {28'b0, data_count}, 32'd0);
    check("async rst empty", {31'b0, empty}, 32'd1);
    check("async rst d_out", d_out, 32'h0);
    check("async rst rd_ack", {31'b0, rd_ack}, 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, '0);
    check("post-rst rd_err", {31'b0, rd_err}, 32'd1);

    // Randomized traffic with phases biased toward full, empty and balanced
    for (int i = 0; i < 3000; i++) begin
      automatic int ph = (i / 150) % 3;
      automatic int pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      automatic int pr = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      step($urandom_range(99) < pw, $urandom_range(99) < pr, $urandom);
    end
    idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
